// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-burst engine.
//   state_e        : frame FSM states
//   CMD_W / RW_BIT : command byte width and position of the read/write flag
//   CntW           : bit-counter width (covers words up to 32 bits)
//   sample_on_rise : SPI mode -> which spi_clk edge samples MOSI
package spi_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWrData,
    StRdData
  } state_e;

  localparam int unsigned CMD_W  = 8;
  localparam int unsigned RW_BIT = 7;
  localparam int unsigned CntW   = 6;

  // mode = {CPOL, CPHA}; modes 0 and 3 sample on the rising edge.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return ~(mode[1] ^ mode[0]);
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Registered edge detector for one (already synchronous) SPI pin.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset; history register resets to RST_VAL
//   ena_i  : when low the history register holds and no edges are reported
//   sig_i  : input level
//   pos_o  : one-cycle pulse on a 0->1 transition
//   neg_o  : one-cycle pulse on a 1->0 transition
module spi_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ena_i,
  input  logic sig_i,
  output logic pos_o,
  output logic neg_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= RST_VAL;
    end else if (ena_i) begin
      sig_q <= sig_i;
    end
  end

  assign pos_o = ena_i & sig_i & ~sig_q;
  assign neg_o = ena_i & ~sig_i & sig_q;

endmodule

// File: rtl/spi_reg_burst.sv
// SPI slave register-access engine with multi-word bursts and address auto-increment.
// An 8-bit command (bit 7 = write, low ADDR_W bits = start address) is followed by any
// number of REG_W-bit data words. During the command byte MISO returns the status byte.
//
// Ports:
//   clk, rstb        : system clock (>= 4x spi_clk), asynchronous active-low reset
//   ena              : global enable; when low all state holds and strobes are low
//   mode             : {CPOL, CPHA}, latched at frame start
//   spi_clk/cs_n/mosi: SPI pins, oversampled in the clk domain
//   spi_miso         : MSB of the transmit shifter
//   reg_addr         : current register address
//   reg_rd           : one-cycle read request; reg_data_i captured on the next clk
//   reg_data_i       : read data
//   reg_data_o       : write data, valid with reg_data_o_dv
//   reg_data_o_dv    : one-cycle write strobe
//   status           : byte shifted out during the command byte
//   frame_active     : high while the FSM is outside IDLE
//   frame_err        : one-cycle pulse when a frame ends mid-word
//
// Build option: define SPI_REG_SYNC_EN to insert 2-flop synchronisers on spi_clk,
// spi_cs_n and spi_mosi (adds 2 clk of latency; clk must then be >= 6x spi_clk).
module spi_reg_burst
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned REG_W    = 8,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_dv,
  input  logic [7:0]        status,
  output logic              frame_active,
  output logic              frame_err
);

  logic sclk_s, csn_s, mosi_s;

`ifdef SPI_REG_SYNC_EN
  localparam logic SclkRst = 1'b1;
  logic [1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_sync_q <= 2'b11;
      csn_sync_q  <= 2'b11;
      mosi_sync_q <= 2'b00;
    end else if (ena) begin
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      csn_sync_q  <= {csn_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign csn_s  = csn_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
`else
  localparam logic SclkRst = 1'b0;
  assign sclk_s = spi_clk;
  assign csn_s  = spi_cs_n;
  assign mosi_s = spi_mosi;
`endif

  logic sclk_pos, sclk_neg, sof, eof;

  spi_edge_det #(
    .RST_VAL(SclkRst)
  ) u_sclk_det (
    .clk_i (clk),
    .rst_ni(rstb),
    .ena_i (ena),
    .sig_i (sclk_s),
    .pos_o (sclk_pos),
    .neg_o (sclk_neg)
  );

  spi_edge_det #(
    .RST_VAL(1'b1)
  ) u_csn_det (
    .clk_i (clk),
    .rst_ni(rstb),
    .ena_i (ena),
    .sig_i (csn_s),
    .pos_o (eof),
    .neg_o (sof)
  );

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [REG_W-1:0]  rx_q, rx_d, rx_nxt;
  logic [REG_W-1:0]  tx_q, tx_d;
  logic [REG_W-1:0]  pend_q, pend_d;
  logic              load_pend_q, load_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inc_q, inc_d;
  logic              rd_q, rd_d;
  logic              dv_q, dv_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [1:0]        mode_q, mode_d;
  logic              sample, change, word_done;
  logic [REG_W-1:0]  stat_word;

  assign sample = sample_on_rise(mode_q) ? sclk_pos : sclk_neg;
  assign change = sample_on_rise(mode_q) ? sclk_neg : sclk_pos;

  always_comb begin
    stat_word = '0;
    stat_word[REG_W-1 -: CMD_W] = status;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    pend_d      = pend_q;
    load_pend_d = load_pend_q;
    addr_d      = addr_q;
    inc_d       = 1'b0;
    rd_d        = 1'b0;
    dv_d        = 1'b0;
    wdata_d     = wdata_q;
    err_d       = 1'b0;
    mode_d      = mode_q;
    word_done   = 1'b0;
    rx_nxt      = {rx_q[REG_W-2:0], mosi_s};

    // Write address advances the cycle after the strobe so dv carries the old address.
    if (inc_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (change && state_q != StIdle) begin
      if (load_pend_q) begin
        tx_d        = pend_q;
        load_pend_d = 1'b0;
      end else begin
        tx_d = {tx_q[REG_W-2:0], 1'b0};
      end
    end

    // reg_rd was visible last cycle: its data is on reg_data_i now.
    if (rd_q) begin
      pend_d      = reg_data_i;
      load_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
      end
      StCmd: begin
        if (sample) begin
          rx_d = rx_nxt;
          if (cnt_q == CntW'(CMD_W - 1)) begin
            cnt_d     = '0;
            word_done = 1'b1;
            addr_d    = rx_nxt[ADDR_W-1:0];
            if (rx_nxt[RW_BIT]) begin
              state_d = StWrData;
            end else begin
              state_d = StRdData;
              rd_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StWrData: begin
        if (sample) begin
          rx_d = rx_nxt;
          if (cnt_q == CntW'(REG_W - 1)) begin
            cnt_d     = '0;
            word_done = 1'b1;
            wdata_d   = rx_nxt;
            dv_d      = 1'b1;
            inc_d     = (AUTO_INC != 0);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRdData: begin
        if (sample) begin
          rx_d = rx_nxt;
          if (cnt_q == CntW'(REG_W - 1)) begin
            cnt_d     = '0;
            word_done = 1'b1;
            rd_d      = 1'b1;
            if (AUTO_INC != 0) begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (eof) begin
      // A word finishing on the same cycle as EOF still counts as complete.
      if (state_q != StIdle && !word_done && (state_q == StCmd || cnt_q != '0)) begin
        err_d = 1'b1;
      end
      state_d     = StIdle;
      cnt_d       = '0;
      load_pend_d = 1'b0;
      rd_d        = 1'b0;  // no prefetch for a word that will never be clocked out
    end

    // SOF also restarts a frame that never saw its EOF.
    if (sof) begin
      state_d     = StCmd;
      cnt_d       = '0;
      mode_d      = mode;
      tx_d        = stat_word;
      pend_d      = stat_word;
      load_pend_d = mode[0];  // CPHA=1: first change edge presents the status MSB
      rd_d        = 1'b0;
      dv_d        = 1'b0;
      inc_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      pend_q      <= '0;
      load_pend_q <= 1'b0;
      addr_q      <= '0;
      inc_q       <= 1'b0;
      rd_q        <= 1'b0;
      dv_q        <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      mode_q      <= 2'b00;
    end else if (ena) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      pend_q      <= pend_d;
      load_pend_q <= load_pend_d;
      addr_q      <= addr_d;
      inc_q       <= inc_d;
      rd_q        <= rd_d;
      dv_q        <= dv_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
    end
  end

  // Strobe registers hold while disabled; gating keeps them from lingering on the pins.
  assign reg_rd        = rd_q & ena;
  assign reg_data_o_dv = dv_q & ena;
  assign frame_err     = err_q & ena;
  assign reg_data_o    = wdata_q;
  assign reg_addr      = addr_q;
  assign spi_miso      = tx_q[REG_W-1];
  assign frame_active  = (state_q != StIdle);

endmodule

// File: tb/tb_spi_reg_burst.sv
module tb_spi_reg_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb, ena, sclk, mosi;
  logic [1:0] mode;
  logic [2:0] cs_n;
  logic [7:0] status;
  int         sel;

  // dut0: defaults; dut1: ADDR_W=3 read target; dut2: REG_W=16, AUTO_INC=0
  logic miso0, rd0, dv0, err0, act0;
  logic [6:0] addr0;
  logic [7:0] wd0;
  logic miso1, rd1, dv1, err1, act1;
  logic [2:0] addr1;
  logic [7:0] wd1, rdata1;
  logic miso2, rd2, dv2, err2, act2;
  logic [6:0] addr2;
  logic [15:0] wd2;

  logic [7:0] regfile [8];
  assign rdata1 = regfile[addr1];

  logic miso_sel;
  assign miso_sel = (sel == 0) ? miso0 : (sel == 1) ? miso1 : miso2;

  spi_reg_burst u_dut0 (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_clk(sclk), .spi_cs_n(cs_n[0]),
    .spi_mosi(mosi), .spi_miso(miso0), .reg_addr(addr0), .reg_rd(rd0), .reg_data_i(8'h00),
    .reg_data_o(wd0), .reg_data_o_dv(dv0), .status(status), .frame_active(act0),
    .frame_err(err0)
  );

  spi_reg_burst #(.ADDR_W(3)) u_dut1 (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_clk(sclk), .spi_cs_n(cs_n[1]),
    .spi_mosi(mosi), .spi_miso(miso1), .reg_addr(addr1), .reg_rd(rd1), .reg_data_i(rdata1),
    .reg_data_o(wd1), .reg_data_o_dv(dv1), .status(status), .frame_active(act1),
    .frame_err(err1)
  );

  spi_reg_burst #(.REG_W(16), .AUTO_INC(0)) u_dut2 (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_clk(sclk), .spi_cs_n(cs_n[2]),
    .spi_mosi(mosi), .spi_miso(miso2), .reg_addr(addr2), .reg_rd(rd2),
    .reg_data_i(16'h0000), .reg_data_o(wd2), .reg_data_o_dv(dv2), .status(status),
    .frame_active(act2), .frame_err(err2)
  );

  // Strobe monitors, sampled on the falling clk edge.
  int          dvn  [3];
  int          rdn  [3];
  int          errn [3];
  logic [31:0] dva  [3][16];
  logic [31:0] dvd  [3][16];

  task automatic log_dv(input int k, input logic [31:0] a, input logic [31:0] d);
    if (dvn[k] < 16) begin
      dva[k][dvn[k]] = a;
      dvd[k][dvn[k]] = d;
    end
    dvn[k]++;
  endtask

  always @(negedge clk) begin
    if (dv0) log_dv(0, 32'(addr0), 32'(wd0));
    if (dv1) log_dv(1, 32'(addr1), 32'(wd1));
    if (dv2) log_dv(2, 32'(addr2), 32'(wd2));
    if (rd0) rdn[0]++;
    if (rd1) rdn[1]++;
    if (rd2) rdn[2]++;
    if (err0) errn[0]++;
    if (err1) errn[1]++;
    if (err2) errn[2]++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic m);
    if (!mode[0]) begin
      mosi = b;
      half();
      m = miso_sel;
      sclk = ~sclk;
      half();
      sclk = ~sclk;
    end else begin
      sclk = ~sclk;
      mosi = b;
      half();
      m = miso_sel;
      sclk = ~sclk;
      half();
    end
  endtask

  task automatic xfer(input int n, input logic [31:0] w, output logic [31:0] r);
    logic m;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      xfer_bit(w[i], m);
      r[i] = m;
    end
  endtask

  task automatic start(input int k, input logic [1:0] md);
    mode = md;
    sclk = md[1];
    half();
    sel = k;
    cs_n[k] = 1'b0;
    half();
  endtask

  task automatic stop();
    half();
    cs_n = 3'b111;
    repeat (6) @(negedge clk);
  endtask

  logic [31:0] r;
  int bd, be, br;

  initial begin
    rstb = 1'b0; ena = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00;
    cs_n = 3'b111; status = 8'hA5; sel = 0;
    for (int i = 0; i < 8; i++) regfile[i] = 8'h00;
    regfile[6] = 8'h5A;
    regfile[7] = 8'hC3;
    regfile[0] = 8'h3C;

    repeat (5) @(negedge clk);
    chk("rst_outs", {miso0, rd0, dv0, err0, act0, addr0, wd0}, 32'h0);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_idle", {miso0, rd0, dv0, err0, act0, addr0, wd0}, 32'h0);

    // Mode 0 write burst 0x83 + 11,22,33
    bd = dvn[0]; be = errn[0];
    start(0, 2'b00);
    xfer(8, 32'h83, r);
    chk("m0_status", r, 32'hA5);
    chk("m0_active", act0, 1);
    xfer(8, 32'h11, r);
    xfer(8, 32'h22, r);
    xfer(8, 32'h33, r);
    stop();
    chk("m0_dv_cnt", dvn[0] - bd, 3);
    chk("m0_a0", dva[0][bd], 3);
    chk("m0_a1", dva[0][bd+1], 4);
    chk("m0_a2", dva[0][bd+2], 5);
    chk("m0_d0", dvd[0][bd], 32'h11);
    chk("m0_d1", dvd[0][bd+1], 32'h22);
    chk("m0_d2", dvd[0][bd+2], 32'h33);
    chk("m0_addr_end", addr0, 6);
    chk("m0_err", errn[0] - be, 0);
    chk("m0_inactive", act0, 0);

    // Modes 1 and 2: single write 0x81 / 0x7E
    status = 8'h3C;
    bd = dvn[0];
    start(0, 2'b01);
    xfer(8, 32'h81, r);
    chk("m1_status", r, 32'h3C);
    xfer(8, 32'h7E, r);
    stop();
    chk("m1_dv_cnt", dvn[0] - bd, 1);
    chk("m1_addr", dva[0][bd], 1);
    chk("m1_data", dvd[0][bd], 32'h7E);

    status = 8'hA5;
    bd = dvn[0];
    start(0, 2'b10);
    xfer(8, 32'h81, r);
    chk("m2_status", r, 32'hA5);
    xfer(8, 32'h7E, r);
    stop();
    chk("m2_dv_cnt", dvn[0] - bd, 1);
    chk("m2_addr", dva[0][bd], 1);
    chk("m2_data", dvd[0][bd], 32'h7E);

    // Mode 3 read burst from addr 6 on a 3-bit address map
    status = 8'h96;
    br = rdn[1]; be = errn[1];
    start(1, 2'b11);
    xfer(8, 32'h06, r);
    chk("m3_status", r, 32'h96);
    xfer(8, 32'h00, r);
    chk("m3_byte0", r, 32'h5A);
    xfer(8, 32'h00, r);
    chk("m3_byte1", r, 32'hC3);
    stop();
    chk("m3_rd_cnt", rdn[1] - br, 3);
    chk("m3_addr_wrap", addr1, 0);
    chk("m3_err", errn[1] - be, 0);

    // Abort after 4 data bits
    status = 8'hA5;
    bd = dvn[0]; be = errn[0];
    start(0, 2'b00);
    xfer(8, 32'h85, r);
    xfer(4, 32'hA, r);
    stop();
    chk("abort_err", errn[0] - be, 1);
    chk("abort_no_dv", dvn[0] - bd, 0);
    chk("abort_idle", act0, 0);
    chk("abort_addr", addr0, 5);

    // REG_W=16, AUTO_INC=0
    bd = dvn[2];
    start(2, 2'b00);
    xfer(8, 32'h82, r);
    chk("w16_status", r, 32'hA5);
    xfer(16, 32'h1234, r);
    xfer(16, 32'hABCD, r);
    stop();
    chk("w16_dv_cnt", dvn[2] - bd, 2);
    chk("w16_a0", dva[2][bd], 2);
    chk("w16_a1", dva[2][bd+1], 2);
    chk("w16_d0", dvd[2][bd], 32'h1234);
    chk("w16_d1", dvd[2][bd+1], 32'hABCD);
    chk("w16_addr_end", addr2, 2);

    // ena low for 20 clk mid-word
    bd = dvn[0]; be = errn[0];
    start(0, 2'b00);
    xfer(8, 32'h90, r);
    xfer(4, 32'h5, r);
    ena = 1'b0;
    repeat (20) @(negedge clk);
    chk("ena_hold_active", act0, 1);
    chk("ena_hold_no_dv", dvn[0] - bd, 0);
    ena = 1'b1;
    xfer(4, 32'hC, r);
    stop();
    chk("ena_dv_cnt", dvn[0] - bd, 1);
    chk("ena_addr", dva[0][bd], 32'h10);
    chk("ena_data", dvd[0][bd], 32'h5C);
    chk("ena_err", errn[0] - be, 0);

    // Reset mid-frame, then a clean frame
    start(0, 2'b00);
    xfer(8, 32'h84, r);
    xfer(3, 32'h5, r);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_outs", {miso0, rd0, dv0, err0, act0, addr0, wd0}, 32'h0);
    cs_n = 3'b111;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    bd = dvn[0];
    start(0, 2'b00);
    xfer(8, 32'h87, r);
    xfer(8, 32'h99, r);
    stop();
    chk("post_rst_dv_cnt", dvn[0] - bd, 1);
    chk("post_rst_addr", dva[0][bd], 7);
    chk("post_rst_data", dvd[0][bd], 32'h99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_reg_burst.md
Name: spi_reg_burst

Overview:
- Parametrised SPI slave register-access engine with multi-word burst transfers and address auto-increment.
- Supports all four SPI modes, latched per frame.
- Decodes an 8-bit command, then streams REG_W-bit data words to or from a register file over a simple strobe interface.
- Sits between the pad-level SPI pins and the register bank; all logic runs in the `clk` domain, with SPI pins oversampled.

Parameters:
- ADDR_W, 7, register address width; legal range 1..7.
- REG_W, 8, data word width; legal range 8..32.
- AUTO_INC, 1, 1 = address increments after each data word; 0 = address held for the whole burst.

Ports:
- clk  in  1  system clock; must run at least 4x spi_clk.
- rstb  in  1  asynchronous active-low reset.
- ena  in  1  global enable; when 0, all state is frozen.
- mode  in  2  {CPOL,CPHA}; latched at frame start.
- spi_clk  in  1  SPI clock.
- spi_cs_n  in  1  SPI chip select, active low.
- spi_mosi  in  1  SPI data in.
- spi_miso  out  1  SPI data out; equals tx_shift[REG_W-1].
- reg_addr  out  ADDR_W  current register address.
- reg_rd  out  1  one-cycle read request; reg_data_i is captured on the next clk.
- reg_data_i  in  REG_W  read data.
- reg_data_o  out  REG_W  write data.
- reg_data_o_dv  out  1  one-cycle write strobe.
- status  in  8  status byte shifted out during the command byte.
- frame_active  out  1  high from SOF until return to IDLE.
- frame_err  out  1  one-cycle pulse when a frame ends mid-word.

Behaviour:
- Reset values:
  - All outputs 0; tx_shift 0; state IDLE.
  - Mode latch = 00.
- Edge detection:
  - spi_clk and spi_cs_n go through registered edge detectors.
  - SOF = cs_n falling; EOF = cs_n rising.
- Edge selection:
  - sample = spi_clk rising when CPOL^CPHA = 0, falling otherwise.
  - change = the opposite edge.
- Command byte (8 bits, MSB first):
  - Bit 7 is rw: 1 = write, 0 = read.
  - Bits [ADDR_W-1:0] are the start address; remaining bits are ignored.
- States:
  - IDLE -> CMD on SOF. At SOF:
    - Latch mode, clear counters.
    - Load tx_shift = {status, zeros}.
    - Set load_pending = 0 if CPHA = 0; otherwise set load_pending = 1 with source status.
  - CMD: shift MOSI on sample edges.
    - On the 8th sample: reg_addr <= cmd address.
    - If rw = 1 -> WR_DATA.
    - If rw = 0 -> pulse reg_rd on the next cycle, capture reg_data_i one cycle later into rd_word, set load_pending, then -> RD_DATA.
  - WR_DATA: on each REG_W-th sample:
    - reg_data_o <= rx word; reg_data_o_dv pulses 1 cycle with the current reg_addr.
    - Next cycle, reg_addr increments if AUTO_INC = 1. Stay in WR_DATA.
  - RD_DATA: on each REG_W-th sample:
    - Increment reg_addr if AUTO_INC = 1.
    - Pulse reg_rd, capture next word, set load_pending. Stay in RD_DATA.
- TX rule (all modes): on a change edge, if load_pending then tx_shift <= pending word and clear load_pending; else shift left, filling with 0.
- Read latency: reg_rd to capture is exactly 1 clk. The pending word must be ready before the next change edge, which the 4x clock ratio guarantees.
- Address wraps modulo 2^ADDR_W; 2^ADDR_W-1 is followed by 0.
- EOF handling:
  - EOF in any state -> IDLE, counters cleared, frame_active cleared.
  - If the bit count within the current word is nonzero (or the command byte is incomplete), pulse frame_err and suppress any strobe for the partial word.
- Simultaneous events:
  - EOF with the final sample edge of a word: the word completes (strobe issued), no frame_err.
  - SOF while not IDLE (glitch): restart as at IDLE.
- ena = 0: edge detectors, FSM and buffers hold; strobes stay low.
- rstb asserted mid-frame: immediate return to reset values; the frame is lost.

Optional Feature:
- Macro: SPI_REG_SYNC_EN.
- Defined: spi_clk, spi_cs_n and spi_mosi pass through 2-flop synchronisers (reset 1, 1, 0) before edge detection. This adds 2 clk latency to all SPI-derived events and requires clk ≥ 6x spi_clk.
- Undefined: inputs feed the edge detectors directly, and the ports must be externally synchronous.

Decomposition:
- Package spi_reg_pkg holds:
  - State enum {IDLE, CMD, WR_DATA, RD_DATA}.
  - CMD_W = 8 and RW_BIT = 7.
  - Mode helper function returning sample polarity.
- Sub-module spi_edge_det (parameter RST_VAL): one instance each for spi_clk and spi_cs_n, producing pos/neg pulses.

Test Plan:
- Mode 0, status = A5: write burst cmd 0x83 + data 11,22,33 -> dv pulses with addr 3,4,5 and data 11,22,33; MISO during the cmd byte = A5.
- Mode 3, read cmd 0x06 with regfile[6] = 5A, [7] = C3, ADDR_W = 3 -> MISO bytes 5A then C3, address wraps to 0, reg_rd issued 3 times.
- Modes 1 and 2: single write 0x81/0x7E -> one dv, data 7E, addr 1.
- cs_n rises after 4 bits of a write data word -> frame_err pulse, no dv, FSM in IDLE, frame_active = 0.
- AUTO_INC = 0, REG_W = 16: write 0x82 + 1234, ABCD -> two dv pulses, both addr 2.
- ena = 0 for 20 clk mid-frame with spi_clk held, then resumed -> transfer completes identically; rstb pulse mid-frame -> all outputs 0, next frame works.
